// File: rtl/arith_unit_arbiter_if.sv
// rtl/arith_unit_arbiter_if.sv - request/response bundle between two requesters, the arbiter and the result consumer
interface arith_unit_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [1:0] req0_op;
  logic       req0_ready;

  logic       req1_valid;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic [1:0] req1_op;
  logic       req1_ready;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic [3:0] rsp_nzvc;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_nzvc
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_nzvc
  );
endinterface

// File: rtl/arith_unit_arbiter.sv
// rtl/arith_unit_arbiter.sv - round-robin arbiter sharing one 8-bit ADD/INC/SUB/DEC unit between two requesters
// Optional per-requester completion counters are built when AU_GRANT_CNT_EN is defined.
module arith_unit_arbiter
`ifdef AU_GRANT_CNT_EN
  #(parameter int CNT_W = 16)
`endif
(
  input  logic                clk,
  input  logic                rst,
  arith_unit_arbiter_if.slave bus
`ifdef AU_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0]    grant0_cnt,
  output logic [CNT_W-1:0]    grant1_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_INC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  state_e     state_q, state_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic [1:0] opc_q, opc_d;
  logic       opid_q, opid_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_result_q, rsp_result_d;
  logic [3:0] rsp_nzvc_q, rsp_nzvc_d;

  logic       grant0, grant1;
  logic       ready0, ready1;
  logic       take;
  logic       rsp_fire;

  logic [8:0] alu_wide;
  logic [7:0] alu_result;
  logic       alu_v, alu_c;
  logic [3:0] alu_nzvc;

  // A lone requester always wins; rr_ptr only breaks ties.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
    grant1 = bus.req1_valid & (~bus.req0_valid | rr_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant0 | grant1) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready0   = (state_q == S_IDLE) & grant0;
    ready1   = (state_q == S_IDLE) & grant1;
    take     = ready0 | ready1;
    rsp_fire = (state_q == S_RESP) & bus.rsp_ready;
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  // Shared datapath sees only the captured operands, never the live request buses.
  always_comb begin
    alu_wide   = 9'd0;
    alu_result = 8'd0;
    alu_v      = 1'b0;
    alu_c      = 1'b0;
    unique case (opc_q)
      OP_ADD: begin
        alu_wide   = {1'b0, opa_q} + {1'b0, opb_q};
        alu_result = alu_wide[7:0];
        alu_c      = alu_wide[8];
        alu_v      = (opa_q[7] == opb_q[7]) && (alu_result[7] != opa_q[7]);
      end
      OP_INC: begin
        alu_result = opa_q + 8'd1;
        alu_v      = (opa_q == 8'h7F);
      end
      OP_SUB: begin
        alu_wide   = {1'b0, opa_q} + {1'b0, ~opb_q} + 9'd1;
        alu_result = alu_wide[7:0];
        alu_c      = alu_wide[8];
        alu_v      = (opa_q[7] != opb_q[7]) && (alu_result[7] != opa_q[7]);
      end
      OP_DEC: begin
        alu_result = opa_q - 8'd1;
        alu_v      = (opa_q == 8'h80);
      end
      default: alu_result = 8'd0;
    endcase
    alu_nzvc = {alu_result[7], (alu_result == 8'd0), alu_v, alu_c};
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    opc_d        = opc_q;
    opid_d       = opid_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_nzvc_d   = rsp_nzvc_q;
    if (take) begin
      opa_d  = ready1 ? bus.req1_a  : bus.req0_a;
      opb_d  = ready1 ? bus.req1_b  : bus.req0_b;
      opc_d  = ready1 ? bus.req1_op : bus.req0_op;
      opid_d = ready1;
    end
    if (state_q == S_EXEC) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = opid_q;
      rsp_result_d = alu_result;
      rsp_nzvc_d   = alu_nzvc;
    end
    if (rsp_fire) begin
      rsp_valid_d = 1'b0;
      rr_ptr_d    = ~rsp_id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= 1'b0;
      opa_q        <= 8'd0;
      opb_q        <= 8'd0;
      opc_q        <= 2'd0;
      opid_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 8'd0;
      rsp_nzvc_q   <= 4'd0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      opc_q        <= opc_d;
      opid_q       <= opid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_nzvc_q   <= rsp_nzvc_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_nzvc   = rsp_nzvc_q;

`ifdef AU_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Counts completed (consumed) responses, saturating rather than wrapping.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (rsp_fire && !rsp_id_q && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + CNT_W'(1);
    if (rsp_fire &&  rsp_id_q && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant0_cnt = cnt0_q;
  assign grant1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_arith_unit_arbiter.sv
// tb/tb_arith_unit_arbiter.sv - self-checking bench for arith_unit_arbiter with directed cases and a randomized reference run
module tb_arith_unit_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  arith_unit_arbiter_if bus();

`ifdef AU_GRANT_CNT_EN
  logic [15:0] grant0_cnt;
  logic [15:0] grant1_cnt;
`endif

  arith_unit_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef AU_GRANT_CNT_EN
    ,
    .grant0_cnt(grant0_cnt),
    .grant1_cnt(grant1_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input bit id, input bit v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    if (!id) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  task automatic bus_idle();
    drive_req(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    drive_req(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic bit ready_of(input bit id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  // Reference: signed/unsigned integer arithmetic, flags derived from range checks.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int ua, ub, sa, sb, u, s;
    logic [7:0] r;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 1'b0;
    case (op)
      2'b00:   begin u = ua + ub; s = sa + sb; c = (u > 255); end
      2'b01:   begin u = ua + 1;  s = sa + 1; end
      2'b10:   begin u = ua - ub; s = sa - sb; c = (ua >= ub); end
      default: begin u = ua - 1;  s = sa - 1; end
    endcase
    r = 8'(u);
    v = (s > 127) || (s < -128);
    return {r, r[7], (r == 8'h00), v, c};
  endfunction

  task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        output bit ok, output logic [7:0] res, output logic [3:0] nzvc,
                        output logic rid, output int lat);
    bit seen;
    ok = 1'b0; res = 8'h00; nzvc = 4'h0; rid = 1'b0; lat = 0; seen = 1'b0;
    bus.rsp_ready = 1'b1;
    drive_req(id, 1'b1, a, b, op);
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (ready_of(id)) seen = 1'b1;
      tick();
    end
    drive_req(id, 1'b0, 8'h00, 8'h00, 2'b00);
    if (seen) begin
      lat = 1;
      for (int i = 0; i < 10 && !ok; i++) begin
        #1;
        if (bus.rsp_valid) begin
          ok = 1'b1; res = bus.rsp_result; nzvc = bus.rsp_nzvc; rid = bus.rsp_id;
        end else begin
          tick();
          lat++;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    tick();
    tick();
    #1;
    total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nzvc} !== 14'h0)
      begin bad++; $display("FAIL reset_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nzvc}, 14'h0); end
    rst = 1'b0;
    drive_req(1'b1, 1'b1, 8'h01, 8'h02, 2'b00);
    #1;
    total++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10)
      begin bad++; $display("FAIL reset_sole_req1 got=%b exp=%b", {bus.req1_ready, bus.req0_ready}, 2'b10); end
    bus_idle();
    tick();
  endtask

  task automatic test_add();
    bit ok; logic [7:0] res; logic [3:0] nzvc; logic rid; int lat;
    do_reset();
    run_op(1'b0, 8'h7F, 8'h01, 2'b00, ok, res, nzvc, rid, lat);
    total++; if (!ok) begin bad++; $display("FAIL add_done got=%0d exp=1", ok); end
    total++; if (lat != 2) begin bad++; $display("FAIL add_latency got=%0d exp=2", lat); end
    total++; if ({rid, res, nzvc} !== {1'b0, 8'h80, 4'b1010})
      begin bad++; $display("FAIL add_rsp got=%h exp=%h", {rid, res, nzvc}, {1'b0, 8'h80, 4'b1010}); end
  endtask

  task automatic test_sub();
    bit ok; logic [7:0] res; logic [3:0] nzvc; logic rid; int lat;
    do_reset();
    run_op(1'b1, 8'h05, 8'h05, 2'b10, ok, res, nzvc, rid, lat);
    total++; if (!ok || lat != 2) begin bad++; $display("FAIL sub_done got=%0d/%0d exp=1/2", ok, lat); end
    total++; if ({rid, res, nzvc} !== {1'b1, 8'h00, 4'b0101})
      begin bad++; $display("FAIL sub_rsp got=%h exp=%h", {rid, res, nzvc}, {1'b1, 8'h00, 4'b0101}); end
  endtask

  task automatic test_dec_inc();
    bit ok; logic [7:0] res; logic [3:0] nzvc; logic rid; int lat;
    do_reset();
    run_op(1'b0, 8'h00, 8'h00, 2'b11, ok, res, nzvc, rid, lat);
    total++; if (!ok || {res, nzvc} !== {8'hFF, 4'b1000})
      begin bad++; $display("FAIL dec_wrap got=%0d/%h exp=1/%h", ok, {res, nzvc}, {8'hFF, 4'b1000}); end
    run_op(1'b0, 8'hFF, 8'h00, 2'b01, ok, res, nzvc, rid, lat);
    total++; if (!ok || {res, nzvc} !== {8'h00, 4'b0100})
      begin bad++; $display("FAIL inc_wrap got=%0d/%h exp=1/%h", ok, {res, nzvc}, {8'h00, 4'b0100}); end
  endtask

  task automatic test_back_to_back();
    int order[$]; int when[$]; int g;
    do_reset();
    bus.rsp_ready = 1'b1;
    drive_req(1'b0, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
    drive_req(1'b1, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
    for (int c = 0; c < 14; c++) begin
      #1;
      total++; if (bus.req0_ready && bus.req1_ready)
        begin bad++; $display("FAIL b2b_exclusive got=11 exp=not both at cycle %0d", c); end
      g = -1;
      if (bus.req0_ready) g = 0;
      else if (bus.req1_ready) g = 1;
      if (g >= 0) begin order.push_back(g); when.push_back(c); end
      tick();
      if (g >= 0) drive_req(g == 1, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
    end
    bus_idle();
    total++; if (order.size() != 5) begin bad++; $display("FAIL b2b_count got=%0d exp=5", order.size()); end
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      total++; if (order[i] != i % 2) begin bad++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, order[i], i % 2); end
      if (i > 0) begin
        total++; if (when[i] - when[i-1] != 3)
          begin bad++; $display("FAIL b2b_interval[%0d] got=%0d exp=3", i, when[i] - when[i-1]); end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] a, b; logic [1:0] op; logic [11:0] exp;
    do_reset();
    a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
    exp = model(a, b, op);
    drive_req(1'b0, 1'b1, a, b, op);
    #1;
    total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b exp=1", bus.req0_ready); end
    tick();
    drive_req(1'b0, 1'b1, 8'h11, 8'h22, 2'b00);
    drive_req(1'b1, 1'b1, 8'h33, 8'h44, 2'b10);
    tick();
    #1;
    total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nzvc} !== {2'b10, exp})
      begin bad++; $display("FAIL stall_first got=%h exp=%h", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nzvc}, {2'b10, exp}); end
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nzvc, bus.req0_ready, bus.req1_ready} !== {2'b10, exp, 2'b00})
        begin bad++; $display("FAIL stall_hold[%0d] got=%h exp=%h", c,
          {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nzvc, bus.req0_ready, bus.req1_ready}, {2'b10, exp, 2'b00}); end
    end
    bus.rsp_ready = 1'b1;
    tick();
    #1;
    total++; if ({bus.rsp_valid, bus.req1_ready, bus.req0_ready} !== 3'b010)
      begin bad++; $display("FAIL stall_release got=%b exp=010", {bus.rsp_valid, bus.req1_ready, bus.req0_ready}); end
    bus_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok; logic [7:0] res; logic [3:0] nzvc; logic rid; int lat;
    do_reset();
    run_op(1'b0, 8'h10, 8'h20, 2'b00, ok, res, nzvc, rid, lat);
    drive_req(1'b1, 1'b1, 8'h40, 8'h01, 2'b10);
    #1;
    total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL rmid_accept got=%b exp=1", bus.req1_ready); end
    tick();
    drive_req(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
    rst = 1'b1;
    tick();
    #1;
    total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nzvc} !== 14'h0)
      begin bad++; $display("FAIL rmid_clear got=%h exp=%h", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nzvc}, 14'h0); end
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_rsp got=%b exp=0", bus.rsp_valid); end
    drive_req(1'b0, 1'b1, 8'h01, 8'h01, 2'b00);
    drive_req(1'b1, 1'b1, 8'h01, 8'h01, 2'b00);
    #1;
    total++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
      begin bad++; $display("FAIL rmid_rr_ptr got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
    bus_idle();
    tick();
  endtask

`ifdef AU_GRANT_CNT_EN
  task automatic test_counters();
    bit ok; logic [7:0] res; logic [3:0] nzvc; logic rid; int lat;
    do_reset();
    #1;
    total++; if ({grant0_cnt, grant1_cnt} !== 32'h0)
      begin bad++; $display("FAIL cnt_reset got=%h exp=0", {grant0_cnt, grant1_cnt}); end
    for (int i = 0; i < 3; i++) run_op(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), ok, res, nzvc, rid, lat);
    #1;
    total++; if ({grant0_cnt, grant1_cnt} !== {16'd0, 16'd3})
      begin bad++; $display("FAIL cnt_req1 got=%h exp=%h", {grant0_cnt, grant1_cnt}, {16'd0, 16'd3}); end
    run_op(1'b0, 8'h01, 8'h01, 2'b00, ok, res, nzvc, rid, lat);
    #1;
    total++; if ({grant0_cnt, grant1_cnt} !== {16'd1, 16'd3})
      begin bad++; $display("FAIL cnt_req0 got=%h exp=%h", {grant0_cnt, grant1_cnt}, {16'd1, 16'd3}); end
  endtask
`endif

  task automatic test_random();
    bit pend[2]; logic [7:0] ra[2]; logic [7:0] rb[2]; logic [1:0] rop[2];
    bit busy, pref, exp_id; int age, g, grants; logic [11:0] exp;
    do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    busy = 1'b0; pref = 1'b0; exp_id = 1'b0; age = 0; grants = 0; exp = 12'h0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(2) == 0) begin
          pend[k] = 1'b1; ra[k] = 8'($urandom); rb[k] = 8'($urandom); rop[k] = 2'($urandom);
        end
        drive_req(k == 1, pend[k], ra[k], rb[k], rop[k]);
      end
      bus.rsp_ready = 1'($urandom);
      #1;
      g = -1;
      if (!busy) begin
        if (pend[0] && pend[1]) g = pref ? 1 : 0;
        else if (pend[0]) g = 0;
        else if (pend[1]) g = 1;
      end
      total++; if ({bus.req1_ready, bus.req0_ready} !== {g == 1, g == 0})
        begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, {bus.req1_ready, bus.req0_ready}, {g == 1, g == 0}); end
      total++; if (bus.rsp_valid !== (busy && age >= 2))
        begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, bus.rsp_valid, (busy && age >= 2)); end
      if (busy && age >= 2) begin
        total++; if ({bus.rsp_id, bus.rsp_result, bus.rsp_nzvc} !== {exp_id, exp})
          begin bad++; $display("FAIL rnd_rsp[%0d] got=%h exp=%h", c, {bus.rsp_id, bus.rsp_result, bus.rsp_nzvc}, {exp_id, exp}); end
      end
      if (busy) begin
        if (age >= 2 && bus.rsp_ready) begin busy = 1'b0; pref = !exp_id; end
        else age++;
      end else if (g >= 0) begin
        busy = 1'b1; age = 1; exp_id = (g == 1);
        exp = model(ra[g], rb[g], rop[g]);
        pend[g] = 1'b0;
        grants++;
      end
      tick();
    end
    total++; if (grants < 40) begin bad++; $display("FAIL rnd_activity got=%0d exp>=40", grants); end
    bus_idle();
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_add();
    test_sub();
    test_dec_inc();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef AU_GRANT_CNT_EN
    test_counters();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
